// File: rtl/sort_result_streamer_if.sv
// -----------------------------------------------------------------------------
// sort_result_streamer_if
// Valid/ready word stream leaving the sort result streamer.
//   out_data   : current stream word
//   out_valid  : out_data is valid
//   out_ready  : sink accepts the word when out_valid & out_ready
//   out_last   : high with the final word of a frame
//   out_index  : 0-based position of the current word in transfer order
// Modports: master = streamer side (drives data), slave = sink side.
// -----------------------------------------------------------------------------
interface sort_result_streamer_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [CNT_W-1:0]  out_index;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready,
        output out_last,
        output out_index
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_last,
        input  out_index
    );
endinterface

// File: rtl/sort_result_streamer.sv
// -----------------------------------------------------------------------------
// sort_result_streamer
// Drain stage for the insertion sorter. A load pulse snapshots the sorter's
// parallel outputs and the occupied-entry count; the valid entries are then
// streamed one word per transfer, ascending or reversed, followed by a
// one-cycle done pulse. The snapshot lets the sorter be refilled meanwhile.
// Ports:
//   clk          : system clock, rising edge
//   rst          : asynchronous active-low reset
//   load         : capture request (single cycle)
//   reverse      : sampled with load; 1 = highest index first
//   sorted_bus   : flattened sorter outputs, word k at [k*DATA_W +: DATA_W]
//   valid_count  : occupied entries, sampled with load (clamped to DEPTH)
//   busy         : high from capture until done
//   done         : one-cycle pulse after the last transfer / empty frame
//   load_drop    : one-cycle pulse when a load arrives while busy
//   out_if       : output word stream (master side)
// -----------------------------------------------------------------------------
module sort_result_streamer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    reverse,
    input  logic [DEPTH*DATA_W-1:0] sorted_bus,
    input  logic [CNT_W-1:0]        valid_count,
    output logic                    busy,
    output logic                    done,
    output logic                    load_drop,
    sort_result_streamer_if.master  out_if
);

    localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FINISH = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] snap_q [DEPTH];
    logic [DATA_W-1:0] snap_d [DEPTH];
    logic [DATA_W-1:0] bus_words [DEPTH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rev_q, rev_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;
    logic [CNT_W-1:0]  n_load;
    logic [IDX_W-1:0]  k_sel;

    // Saturate the requested count at the number of physical entries.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] vc);
        return (vc > DEPTH_C) ? DEPTH_C : vc;
    endfunction

    // Map a transfer position to the snapshot entry that goes out there.
    function automatic logic [CNT_W-1:0] frame_pos(input logic [CNT_W-1:0] idx,
                                                   input logic [CNT_W-1:0] n,
                                                   input logic             rev);
        return rev ? (n - CNT_W'(1) - idx) : idx;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            bus_words[i] = sorted_bus[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        rev_d   = rev_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        drop_d  = 1'b0;
        n_load  = clamp_count(valid_count);
        k_sel   = '0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    snap_d = bus_words;
                    cnt_d  = n_load;
                    rev_d  = reverse;
                    idx_d  = '0;
                    busy_d = 1'b1;
                    if (n_load != '0) begin
                        // First word comes straight from the bus so it is
                        // presented the cycle after capture.
                        k_sel   = IDX_W'(frame_pos('0, n_load, reverse));
                        data_d  = bus_words[k_sel];
                        valid_d = 1'b1;
                        last_d  = (n_load == CNT_W'(1));
                        state_d = STREAM;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end

            STREAM: begin
                drop_d = load;
                if (out_if.out_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        data_d  = '0;
                        idx_d   = '0;
                        state_d = FINISH;
                    end else begin
                        idx_d  = idx_q + CNT_W'(1);
                        k_sel  = IDX_W'(frame_pos(idx_d, cnt_q, rev_q));
                        data_d = snap_q[k_sel];
                        last_d = (idx_d == cnt_q - CNT_W'(1));
                    end
                end
            end

            FINISH: begin
                drop_d  = load;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                snap_q[i] <= '0;
            end
            cnt_q   <= '0;
            rev_q   <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            rev_q   <= rev_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    assign out_if.out_data  = data_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_last  = last_q;
    assign out_if.out_index = idx_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign load_drop        = drop_q;

endmodule
